// File: rtl/pixel_scan_pkg.sv
// Shared definitions for the pixel digital scan: default geometry, FSM states, out_data layout.
// Also imported by the scanner and the packer so that all three agree on field placement.
package pixel_scan_pkg;

    localparam int unsigned ROW_DEF        = 400;
    localparam int unsigned COLUMN_DEF     = 32;
    localparam int unsigned DATA_W_DEF     = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 16;
    localparam int unsigned RowWDef        = $clog2(ROW_DEF);
    localparam int unsigned ColWDef        = $clog2(COLUMN_DEF);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitMk  = 2'd1,
        StCapture = 2'd2
    } scan_state_e;

    // out_data layout is {row, col, data}, data in the LSBs
    localparam int unsigned DataLsb = 0;

    function automatic int unsigned col_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned row_lsb(input int unsigned data_w, input int unsigned col_w);
        return data_w + col_w;
    endfunction

endpackage

// File: rtl/pixel_readout_fifo.sv
// Synchronous FIFO with a registered head word: data_o/valid_o come straight from flops.
// Simultaneous push and pop on a full FIFO are both accepted.
module pixel_readout_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             full_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             valid_q;
    logic [WIDTH-1:0] head_q, head_d;
    logic             pop;
    logic             push_ok;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign pop     = valid_q & ready_i;
    assign push_ok = push_i & (~full_o | pop);
    assign valid_o = valid_q;
    assign data_o  = head_q;

    // Pointer/count update and selection of the word that becomes the head next cycle
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = '0;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CntW'(1);
        end
        // The word being written is the new head only when it lands where the read pointer goes
        if (count_d != '0) begin
            if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
                head_d = data_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= (count_d != '0);
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/pixel_scan_readout.sv
// Receive side of the pixel digital scan: tags each returned sample with its (row,col),
// re-aligns on the frame marker and buffers words for the packer.
// Build option: PIXEL_READOUT_HITONLY_EN drops zero-valued samples (zero suppression).
module pixel_scan_readout
    import pixel_scan_pkg::*;
#(
    parameter int unsigned ROW        = ROW_DEF,
    parameter int unsigned COLUMN     = COLUMN_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                                            clk_s,
    input  logic                                            rst_n_s,
    input  logic                                            enable_s,
    input  logic                                            speak_s,
    input  logic                                            marker_a,
    input  logic [DATA_W-1:0]                               pix_data,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [$clog2(ROW)+$clog2(COLUMN)+DATA_W-1:0]    out_data,
    output logic                                            frame_start,
    output logic                                            frame_done,
    output logic                                            overflow,
    output logic                                            sync_err
);

    localparam int unsigned RowW   = $clog2(ROW);
    localparam int unsigned ColW   = $clog2(COLUMN);
    localparam int unsigned OutW   = RowW + ColW + DATA_W;
    localparam int unsigned ColLsb = col_lsb(DATA_W);
    localparam int unsigned RowLsb = row_lsb(DATA_W, ColW);

    logic [2:0]      mk_sync_q;
    logic            mk_rise;
    scan_state_e     state_q;
    logic [RowW-1:0] row_q, samp_row, row_nxt;
    logic [ColW-1:0] col_q, samp_col, col_nxt;
    logic            at_origin;
    logic            sample;
    logic            last_row, last_col;
    logic            push_req;
    logic            fifo_full;
    logic            drop;
    logic [OutW-1:0] push_word;
    logic            frame_start_q, frame_done_q, overflow_q, sync_err_q;

    // Two-flop synchroniser for the marker plus one history flop for edge detection
    always_ff @(posedge clk_s or negedge rst_n_s) begin
        if (!rst_n_s) begin
            mk_sync_q <= '0;
        end else begin
            mk_sync_q <= {mk_sync_q[1:0], marker_a};
        end
    end

    assign mk_rise   = mk_sync_q[1] & ~mk_sync_q[2];
    assign at_origin = (row_q == '0) && (col_q == '0);
    assign sample    = (state_q == StCapture) && enable_s && speak_s;

    // A marker in the same cycle as a strobe re-addresses that sample to (0,0)
    assign samp_row  = mk_rise ? '0 : row_q;
    assign samp_col  = mk_rise ? '0 : col_q;
    assign last_col  = (samp_col == ColW'(COLUMN - 1));
    assign last_row  = (samp_row == RowW'(ROW - 1));

    // Raster-order successor of the sampled address
    always_comb begin
        col_nxt = samp_col + ColW'(1);
        row_nxt = samp_row;
        if (last_col) begin
            col_nxt = '0;
            row_nxt = last_row ? '0 : samp_row + RowW'(1);
        end
    end

    // Pack the tagged word
    always_comb begin
        push_word                     = '0;
        push_word[DataLsb +: DATA_W]  = pix_data;
        push_word[ColLsb +: ColW]     = samp_col;
        push_word[RowLsb +: RowW]     = samp_row;
    end

`ifdef PIXEL_READOUT_HITONLY_EN
    assign push_req = sample && (pix_data != '0);
`else
    assign push_req = sample;
`endif

    // Only a push that the FIFO cannot take this cycle counts as a drop
    assign drop = push_req & fifo_full & ~(out_valid & out_ready);

    // Scan FSM with address counters and registered status flags
    always_ff @(posedge clk_s or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q       <= StIdle;
            row_q         <= '0;
            col_q         <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            if (!enable_s) begin
                state_q    <= StIdle;
                overflow_q <= 1'b0;
                sync_err_q <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        state_q <= StWaitMk;
                    end
                    StWaitMk: begin
                        if (mk_rise) begin
                            state_q <= StCapture;
                            row_q   <= '0;
                            col_q   <= '0;
                        end
                    end
                    StCapture: begin
                        if (mk_rise && !at_origin) begin
                            sync_err_q <= 1'b1;
                        end
                        if (speak_s) begin
                            row_q         <= row_nxt;
                            col_q         <= col_nxt;
                            frame_start_q <= (samp_row == '0) && (samp_col == '0);
                            frame_done_q  <= last_row && last_col;
                        end else if (mk_rise) begin
                            row_q <= '0;
                            col_q <= '0;
                        end
                        if (drop) begin
                            overflow_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign overflow    = overflow_q;
    assign sync_err    = sync_err_q;

    pixel_readout_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OutW)
    ) u_fifo (
        .clk_i   (clk_s),
        .rst_ni  (rst_n_s),
        .push_i  (push_req),
        .data_i  (push_word),
        .ready_i (out_ready),
        .full_o  (fifo_full),
        .valid_o (out_valid),
        .data_o  (out_data)
    );

endmodule

// File: tb/tb_pixel_scan_readout.sv
// Scoreboard bench for pixel_scan_readout on a 4x4 matrix with a 4-entry buffer.
// Expected words are queued as stimulus is issued; a negedge monitor pops and compares.
module tb_pixel_scan_readout;

    logic        clk_s;
    logic        rst_n_s;
    logic        enable_s;
    logic        speak_s;
    logic        marker_a;
    logic [7:0]  pix_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        frame_start;
    logic        frame_done;
    logic        overflow;
    logic        sync_err;

    int          errors = 0;
    int          checks = 0;
    int          fd_cnt = 0;
    int          fs_cnt = 0;
    int          pop_cnt = 0;
    logic [11:0] exp_q[$];
    logic [11:0] mon_exp;

    pixel_scan_readout #(
        .ROW        (4),
        .COLUMN     (4),
        .DATA_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_s       (clk_s),
        .rst_n_s     (rst_n_s),
        .enable_s    (enable_s),
        .speak_s     (speak_s),
        .marker_a    (marker_a),
        .pix_data    (pix_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .sync_err    (sync_err)
    );

    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    function automatic logic [11:0] word(input int r, input int c, input logic [7:0] d);
        logic [1:0] rr;
        logic [1:0] cc;
        rr = r[1:0];
        cc = c[1:0];
        return {rr, cc, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: counts pulses and checks every accepted word against the scoreboard
    always @(negedge clk_s) begin
        if (rst_n_s) begin
            if (frame_done) fd_cnt++;
            if (frame_start) fs_cnt++;
            if (out_valid && out_ready) begin
                checks++;
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %h, required no word", out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (out_data !== mon_exp) begin
                        errors++;
                        $display("FAIL word: got %h, required %h", out_data, mon_exp);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk_s);
        #1;
    endtask

    task automatic speak(input logic [7:0] d, input int r, input int c, input bit exp);
        if (exp) exp_q.push_back(word(r, c, d));
        speak_s  = 1'b1;
        pix_data = d;
        cyc();
        speak_s  = 1'b0;
        pix_data = '0;
    endtask

    // Marker pulse; returns once the reload has taken effect
    task automatic marker_pulse();
        marker_a = 1'b1;
        cyc();
        marker_a = 1'b0;
        cyc();
        cyc();
    endtask

    // Marker whose reload coincides with a strobe
    task automatic marker_with_speak(input logic [7:0] d);
        marker_a = 1'b1;
        cyc();
        marker_a = 1'b0;
        cyc();
        speak(d, 0, 0, 1'b1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            cyc();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int p0;
        rst_n_s   = 1'b0;
        enable_s  = 1'b0;
        speak_s   = 1'b0;
        marker_a  = 1'b0;
        pix_data  = '0;
        out_ready = 1'b1;
        repeat (3) cyc();
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_flags", {frame_start, frame_done, overflow, sync_err}, 0);
        rst_n_s = 1'b1;
        cyc();

        // 1: clean frame
        enable_s = 1'b1;
        cyc();
        marker_pulse();
        fd_cnt = 0; fs_cnt = 0; p0 = pop_cnt;
        for (int i = 0; i < 16; i++) speak(8'h10 + 8'(i), i / 4, i % 4, 1'b1);
        check("t1_frame_done_pulse", frame_done, 1);
        wait_drain("t1_drain");
        check("t1_words", pop_cnt - p0, 16);
        check("t1_fd_cnt", fd_cnt, 1);
        check("t1_fs_cnt", fs_cnt, 1);
        check("t1_flags", {overflow, sync_err}, 0);

        // 2: two frames, marker at the start of each
        fd_cnt = 0; fs_cnt = 0;
        for (int f = 0; f < 2; f++) begin
            marker_pulse();
            for (int i = 0; i < 16; i++) speak(8'h20 + 8'(16 * f + i), i / 4, i % 4, 1'b1);
        end
        wait_drain("t2_drain");
        check("t2_fd_cnt", fd_cnt, 2);
        check("t2_fs_cnt", fs_cnt, 2);
        check("t2_sync_err", sync_err, 0);

        // 3: marker mid-frame, coinciding with a strobe
        marker_pulse();
        for (int i = 0; i < 5; i++) speak(8'h50 + 8'(i), i / 4, i % 4, 1'b1);
        marker_with_speak(8'h5A);
        check("t3_sync_err_set", sync_err, 1);
        speak(8'h5B, 0, 1, 1'b1);
        wait_drain("t3_drain");
        enable_s = 1'b0;
        cyc();
        check("t3_sync_err_clear", sync_err, 0);

        // 4: backpressure, full push+pop, overflow drops
        enable_s = 1'b1;
        cyc();
        out_ready = 1'b0;
        marker_pulse();
        check("t4_no_sync_err", sync_err, 0);
        for (int i = 0; i < 4; i++) speak(8'h60 + 8'(i), 0, i, 1'b1);
        check("t4_full_valid", out_valid, 1);
        check("t4_no_ovf_yet", overflow, 0);
        out_ready = 1'b1;
        speak(8'h64, 1, 0, 1'b1);
        out_ready = 1'b0;
        check("t4_push_pop_full", overflow, 0);
        speak(8'h65, 1, 1, 1'b0);
        speak(8'h66, 1, 2, 1'b0);
        check("t4_overflow", overflow, 1);
        check("t4_head", out_data, word(0, 1, 8'h61));
        out_ready = 1'b1;
        wait_drain("t4_drain");
        marker_pulse();
        check("t4_resync_err", sync_err, 1);
        for (int i = 0; i < 4; i++) speak(8'h70 + 8'(i), 0, i, 1'b1);
        wait_drain("t4_next_frame");
        check("t4_ovf_sticky", overflow, 1);

        // 5: asynchronous reset mid-frame
        out_ready = 1'b0;
        marker_pulse();
        for (int i = 0; i < 6; i++) speak(8'h80 + 8'(i), 0, 0, 1'b0);
        check("t5_pre_valid", out_valid, 1);
        speak_s  = 1'b1;
        pix_data = 8'h87;
        #2;
        rst_n_s = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_data", out_data, 0);
        check("t5_rst_flags", {frame_start, frame_done, overflow, sync_err}, 0);
        speak_s  = 1'b0;
        pix_data = '0;
        cyc();
        rst_n_s   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) speak(8'h90 + 8'(i), 0, 0, 1'b0);
        check("t5_idle_no_words", out_valid, 0);
        check("t5_queue_empty", exp_q.size(), 0);

`ifdef PIXEL_READOUT_HITONLY_EN
        // 6: zero suppression
        marker_pulse();
        fd_cnt = 0; p0 = pop_cnt;
        for (int i = 0; i < 16; i++) begin
            if (i == 6) speak(8'hA6, 1, 2, 1'b1);
            else if (i == 15) speak(8'hBF, 3, 3, 1'b1);
            else speak(8'h00, i / 4, i % 4, 1'b0);
        end
        wait_drain("t6_drain");
        repeat (3) cyc();
        check("t6_words", pop_cnt - p0, 2);
        check("t6_fd_cnt", fd_cnt, 1);
`endif

        repeat (3) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
